uart_in_reg: RTL

- Input-side counterpart to the processor's output register: receives an asynchronous 8N1 serial stream on `rxd`.
- Assembles two bytes into one 16-bit word and holds it for the processor's IN instruction.
- The processor consumes the word with a one-cycle read strobe during its execute phase.
- `valid` and sticky error flags report status to the control logic.

---
 rtl/simple_io_pkg.sv | 18 +
 rtl/uart_rx_byte.sv | 138 +++++++++++++
 rtl/uart_in_reg.sv | 100 ++++++++++
 3 files changed

// File: rtl/simple_io_pkg.sv
// Shared types and constants for the serial input register.
// Byte-pointer values select which half of the word the next accepted byte fills.
package simple_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int   UART_BITS = 8;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with 2-flop synchronizer; optional even parity via UART_IN_PARITY_EN.
// Latency: byte_valid_o pulses combinationally in the cycle the stop bit is sampled.
// Backpressure: none; the consumer must take the byte in the pulse cycle.
module uart_rx_byte
    import simple_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_pulse_o,
    output logic       parity_err_pulse_o
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT = 3'(UART_BITS - 1);

`ifdef UART_IN_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic          sync1_q, sync2_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          hold_q, hold_d;
    logic          par_bad_q, par_bad_d;
    logic          rxs;
    logic          tick;

    assign rxs  = sync2_q;
    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            hold_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            sync1_q   <= rxd_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        idx_d              = idx_q;
        shift_d            = shift_q;
        hold_d             = hold_q;
        par_bad_d          = par_bad_q;
        byte_valid_o       = 1'b0;
        frame_err_pulse_o  = 1'b0;
        parity_err_pulse_o = 1'b0;

        case (state_q)
            IDLE: begin
                // After a framing error the line must return high before a new start is trusted.
                if (hold_q) begin
                    if (rxs) hold_d = 1'b0;
                end else if (!rxs) begin
                    state_d   = START;
                    cnt_d     = CNT_HALF;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = CNT_FULL;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == LAST_BIT) state_d = AFTER_DATA;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
`ifdef UART_IN_PARITY_EN
            PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_bad_d = rxs ^ (^shift_q);
                    state_d   = STOP;
                    cnt_d     = CNT_FULL;
                end
            end
`endif
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d            = IDLE;
                    parity_err_pulse_o = par_bad_q;
                    if (!rxs) begin
                        frame_err_pulse_o = 1'b1;
                        hold_d            = 1'b1;
                    end else if (!par_bad_q) begin
                        byte_valid_o = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/uart_in_reg.sv
// Serial input word register: two 8N1 bytes form one word for IN; UART_IN_PARITY_EN adds even parity.
// Latency: valid rises 1 clk after the stop-bit sample of the second byte.
// Backpressure: none; a word completing while valid=1 and unread is dropped and flags overrun.
module uart_in_reg
    import simple_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              rd_inr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              overrun,
    output logic              frame_err,
    output logic              parity_err
);

    logic              byte_vld;
    logic [7:0]        rx_byte;
    logic              frame_pulse;
    logic              parity_pulse;

    logic              ptr_q, ptr_d;
    logic [7:0]        stage_q, stage_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_q, frame_d;
    logic              parity_q, parity_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk               (clk),
        .rst               (rst),
        .rxd_i             (rxd),
        .byte_valid_o      (byte_vld),
        .byte_o            (rx_byte),
        .frame_err_pulse_o (frame_pulse),
        .parity_err_pulse_o(parity_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= LOW;
            stage_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            stage_q   <= stage_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
            parity_q  <= parity_d;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        stage_d   = stage_q;
        data_d    = data_q;
        valid_d   = valid_q & ~rd_inr;
        overrun_d = overrun_q & ~rd_inr;
        frame_d   = frame_pulse | (frame_q & ~rd_inr);
        parity_d  = parity_pulse | (parity_q & ~rd_inr);

        // A discarded byte breaks word alignment, so assembly restarts at the low byte.
        if (frame_pulse || parity_pulse) begin
            ptr_d = LOW;
        end else if (byte_vld) begin
            if (ptr_q == LOW) begin
                stage_d = rx_byte;
                ptr_d   = HIGH;
            end else begin
                ptr_d = LOW;
                if (!valid_q || rd_inr) begin
                    data_d  = {rx_byte, stage_q};
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_q;
    assign parity_err = parity_q;

endmodule
